lcd_digit_writer: RTL and testbench
===================================

// Module: lcd_digit_writer
// PURPOSE
//  Parametrised successor of the safe's LCD datapath. Owns the complete HD44780 8-bit write sequence:
//  power-up wait, fixed init command list, then on request writes a DDRAM address command and
//  NUM_DIGITS hex digits as ASCII. Generates E strobe timing itself; sits between safe control/counters and LCD pins.
// PARAMETERS
//  NUM_DIGITS    4      digits written per refresh (1..16), digit 0 = leftmost = MSB nibble of digits bus
//  DDRAM_ADDR    8'hCE  set-DDRAM-address command issued before each digit string
//  PWRUP_CYC     16'd20000  cycles waited after reset release before first init command
//  E_CYC         8'd12  cycles lcd_e is held high per byte
//  WAIT_CYC      16'd2000 cycles after E falls before next byte (normal commands/data)
//  CLR_WAIT_CYC  16'd80000 post-E wait used only after clear-display command (8'h01)
//  AUTO_REFRESH  0      1: new refresh starts automatically the cycle after done
// PORTS
//  clk      in   1               system clock
//  rst_n    in   1               synchronous reset, active low
//  digits   in   4*NUM_DIGITS    hex digit values; sampled only on accepted start
//  start    in   1               refresh request; accepted only when ready=1
//  ready    out  1               1 only in IDLE (init finished, no refresh in progress)
//  done     out  1               one-cycle pulse when last digit byte's wait completes
//  lcd_db   out  8               LCD data bus
//  lcd_rs   out  1               0 = command, 1 = data
//  lcd_rw   out  1               tied 0 (write only)
//  lcd_e    out  1               enable strobe
// BEHAVIOUR
//  - One clock; reset synchronous, active low. rst_n=0 at an edge -> next-cycle state PWRUP, lcd_db=8'h00,
//    lcd_rs=0, lcd_e=0, lcd_rw=0, ready=0, done=0, all counters cleared. Applies mid-byte too: E drops
//    immediately, whole init replays.
//  - States: PWRUP -> INIT -> IDLE -> ADDR -> DATA -> (IDLE | ADDR if AUTO_REFRESH).
//  - PWRUP: counts PWRUP_CYC cycles starting with first cycle rst_n=1, then INIT.
//  - INIT: commands, RS=0, in order 8'h38, 8'h0C, 8'h06, 8'h01; then IDLE.
//  - Byte write = 3 phases: SETUP 1 cycle (db/rs driven, e=0); PULSE E_CYC cycles (e=1);
//    HOLD WAIT_CYC cycles (e=0, db/rs unchanged); HOLD uses CLR_WAIT_CYC when byte is 8'h01 with RS=0.
//    Byte duration = 1+E_CYC+wait. db/rs never change while e=1 or in the cycle e falls.
//  - IDLE: ready=1, e=0, db/rs hold last values. start=1 -> latch digits, ready=0 next cycle, go ADDR.
//  - start while ready=0 ignored (not queued); digits changes after latch do not affect current refresh.
//  - ADDR: writes DDRAM_ADDR with RS=0. DATA: writes NUM_DIGITS bytes with RS=1, digit 0 first.
//  - ASCII map: d<=9 -> 8'h30+d; d>=10 -> 8'h41+(d-10) ('A'..'F'); 8-bit arithmetic, no overflow possible.
//  - done=1 in the last HOLD cycle of the final digit; next cycle IDLE (ready=1) or, if AUTO_REFRESH=1,
//    ADDR with digits relatched that same cycle; start ignored when AUTO_REFRESH=1 after first refresh.
//  - Counters sized for max parameter value; wait counter reloads per byte, no wrap between bytes.
// TESTING (bench params: NUM_DIGITS=4, PWRUP_CYC=10, E_CYC=2, WAIT_CYC=3, CLR_WAIT_CYC=5)
//  1 Release reset -> E pulses carry 38,0C,06,01 with RS=0; first E rise at cycle 11; ready=1 at cycle 36.
//  2 digits=16'h1234, start in IDLE -> CE (RS=0) then 31,32,33,34 (RS=1); done exactly one cycle, 30 cycles
//    after start accepted; ready=1 next cycle.
//  3 digits=16'hA0F9 -> data bytes 41,30,46,39.
//  4 start held high and digits changed to 16'hFFFF mid-refresh -> bytes still from latched value; no second
//    refresh until ready=1 and start re-sampled.
//  5 rst_n=0 for one cycle during a PULSE phase -> lcd_e=0, db=00 next cycle; full PWRUP+INIT replays.
//  6 AUTO_REFRESH=1 -> after done, CE issued again without start; checker confirms e never high with db changing.

Source files
------------

// File: rtl/lcd_digit_writer_if.sv
// Request/status and LCD pin bundle for lcd_digit_writer.
// master = controller side (drives digits/start), slave = the writer.
interface lcd_digit_writer_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    start;
    logic                    ready;
    logic                    done;
    logic [7:0]              lcd_db;
    logic                    lcd_rs;
    logic                    lcd_rw;
    logic                    lcd_e;

    modport master (
        output digits, start,
        input  ready, done, lcd_db, lcd_rs, lcd_rw, lcd_e
    );

    modport slave (
        input  digits, start,
        output ready, done, lcd_db, lcd_rs, lcd_rw, lcd_e
    );
endinterface

// File: rtl/lcd_digit_writer.sv
// HD44780 8-bit write sequencer: power-up wait, fixed init list, then on
// request one DDRAM address command followed by NUM_DIGITS hex digits as ASCII.
// Every byte is SETUP (1) + PULSE (E_CYC, e=1) + HOLD (wait cycles).
module lcd_digit_writer #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter logic [7:0]  DDRAM_ADDR   = 8'hCE,
    parameter int unsigned PWRUP_CYC    = 20000,
    parameter int unsigned E_CYC        = 12,
    parameter int unsigned WAIT_CYC     = 2000,
    parameter int unsigned CLR_WAIT_CYC = 80000,
    parameter bit          AUTO_REFRESH = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    lcd_digit_writer_if.slave bus
);
    localparam int unsigned M1   = (PWRUP_CYC > WAIT_CYC) ? PWRUP_CYC : WAIT_CYC;
    localparam int unsigned M2   = (CLR_WAIT_CYC > E_CYC) ? CLR_WAIT_CYC : E_CYC;
    localparam int unsigned MAXC = (M1 > M2) ? M1 : M2;
    localparam int          CW   = $clog2(MAXC + 1);
    localparam int          IW   = 5;
    localparam int          DW   = 4 * NUM_DIGITS;

    typedef enum logic [2:0] {S_PWRUP, S_INIT, S_IDLE, S_ADDR, S_DATA} state_t;
    typedef enum logic [1:0] {P_SETUP, P_PULSE, P_HOLD} phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      db_q, db_d;
    logic            rs_q, rs_d;
    logic [DW-1:0]   lat_q, lat_d;
    logic            done_c;
    logic [CW-1:0]   hold_last;

    function automatic logic [7:0] init_cmd(input logic [IW-1:0] i);
        case (i)
            5'd0:    return 8'h38;  // 8-bit bus, 2 lines, 5x8 font
            5'd1:    return 8'h0C;  // display on, cursor off
            5'd2:    return 8'h06;  // increment, no shift
            default: return 8'h01;  // clear display
        endcase
    endfunction

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        if (d <= 4'd9) return 8'h30 + {4'h0, d};
        return 8'h41 + ({4'h0, d} - 8'd10);
    endfunction

    // digit 0 is the leftmost character, i.e. the most significant nibble
    function automatic logic [3:0] dig_at(input logic [DW-1:0] v, input logic [IW-1:0] i);
        logic [DW-1:0] s;
        s = v >> (4 * (int'(NUM_DIGITS) - 1 - int'(i)));
        return s[3:0];
    endfunction

    // the clear command needs the long post-strobe wait
    assign hold_last = (!rs_q && db_q == 8'h01) ? CW'(CLR_WAIT_CYC - 1) : CW'(WAIT_CYC - 1);

    // state register; reset restarts the whole power-up/init sequence
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_PWRUP;
            phase_q <= P_SETUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            db_q    <= 8'h00;
            rs_q    <= 1'b0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            db_q    <= db_d;
            rs_q    <= rs_d;
            lat_q   <= lat_d;
        end
    end

    // next-state: byte phase engine plus what to send when a byte ends
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        db_d    = db_q;
        rs_d    = rs_q;
        lat_d   = lat_q;
        done_c  = 1'b0;
        case (state_q)
            S_PWRUP: begin
                if (cnt_q == CW'(PWRUP_CYC - 1)) begin
                    state_d = S_INIT;
                    phase_d = P_SETUP;
                    cnt_d   = '0;
                    idx_d   = '0;
                    db_d    = init_cmd('0);
                    rs_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ADDR;
                    lat_d   = bus.digits;
                    phase_d = P_SETUP;
                    cnt_d   = '0;
                    db_d    = DDRAM_ADDR;
                    rs_d    = 1'b0;
                end
            end
            default: begin
                case (phase_q)
                    P_SETUP: begin
                        phase_d = P_PULSE;
                        cnt_d   = '0;
                    end
                    P_PULSE: begin
                        if (cnt_q == CW'(E_CYC - 1)) begin
                            phase_d = P_HOLD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        if (cnt_q != hold_last) begin
                            cnt_d = cnt_q + CW'(1);
                        end else begin
                            phase_d = P_SETUP;
                            cnt_d   = '0;
                            if (state_q == S_INIT) begin
                                if (idx_q == IW'(3)) begin
                                    state_d = S_IDLE;
                                end else begin
                                    idx_d = idx_q + IW'(1);
                                    db_d  = init_cmd(idx_q + IW'(1));
                                end
                            end else if (state_q == S_ADDR) begin
                                state_d = S_DATA;
                                idx_d   = '0;
                                db_d    = to_ascii(dig_at(lat_q, '0));
                                rs_d    = 1'b1;
                            end else if (idx_q == IW'(NUM_DIGITS - 1)) begin
                                done_c = 1'b1;
                                if (AUTO_REFRESH) begin
                                    state_d = S_ADDR;
                                    lat_d   = bus.digits;
                                    db_d    = DDRAM_ADDR;
                                    rs_d    = 1'b0;
                                end else begin
                                    state_d = S_IDLE;
                                end
                            end else begin
                                idx_d = idx_q + IW'(1);
                                db_d  = to_ascii(dig_at(lat_q, idx_q + IW'(1)));
                            end
                        end
                    end
                endcase
            end
        endcase
    end

    assign bus.lcd_e  = (phase_q == P_PULSE);
    assign bus.lcd_db = db_q;
    assign bus.lcd_rs = rs_q;
    assign bus.lcd_rw = 1'b0;
    assign bus.ready  = (state_q == S_IDLE);
    assign bus.done   = done_c;
endmodule

// File: tb/tb_lcd_digit_writer.sv
// Bench for lcd_digit_writer: dut0 (manual refresh) and dut1 (AUTO_REFRESH).
// A byte-queue timing model predicts every output cycle; directed tests pin
// byte sequences and cycle positions with hand-computed literals.
module tb_lcd_digit_writer;
    localparam int ND = 4, PW = 10, EC = 2, WC = 3, CC = 5;

    typedef struct packed {
        logic       fin;
        logic       rs;
        logic [7:0] db;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n_s, start_s;
    logic [1:0][15:0] dig_s;
    logic [1:0]       e_w, rs_w, rw_w, rdy_w, done_w;
    logic [1:0][7:0]  db_w;

    int n_run = 0, n_fail = 0;

    lcd_digit_writer_if #(.NUM_DIGITS(ND)) bus0();
    lcd_digit_writer_if #(.NUM_DIGITS(ND)) bus1();

    assign bus0.digits = dig_s[0];
    assign bus0.start  = start_s[0];
    assign bus1.digits = dig_s[1];
    assign bus1.start  = start_s[1];
    assign e_w    = {bus1.lcd_e,  bus0.lcd_e};
    assign rs_w   = {bus1.lcd_rs, bus0.lcd_rs};
    assign rw_w   = {bus1.lcd_rw, bus0.lcd_rw};
    assign rdy_w  = {bus1.ready,  bus0.ready};
    assign done_w = {bus1.done,   bus0.done};
    assign db_w[0] = bus0.lcd_db;
    assign db_w[1] = bus1.lcd_db;

    lcd_digit_writer #(.NUM_DIGITS(ND), .DDRAM_ADDR(8'hCE), .PWRUP_CYC(PW), .E_CYC(EC),
        .WAIT_CYC(WC), .CLR_WAIT_CYC(CC), .AUTO_REFRESH(1'b0))
        dut0 (.clk(clk), .rst_n(rst_n_s[0]), .bus(bus0));

    lcd_digit_writer #(.NUM_DIGITS(ND), .DDRAM_ADDR(8'hCE), .PWRUP_CYC(PW), .E_CYC(EC),
        .WAIT_CYC(WC), .CLR_WAIT_CYC(CC), .AUTO_REFRESH(1'b1))
        dut1 (.clk(clk), .rst_n(rst_n_s[1]), .bus(bus1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    for (genvar g = 0; g < 2; g++) begin : g_mdl
        localparam bit AUTO = (g == 1);
        ent_t       q[$];
        int         off = 0, pwr = 0;
        logic [7:0] ldb = 8'h00;
        logic       lrs = 1'b0;
        bit         live = 0, jr = 0, pe = 0;
        logic [8:0] pv = '0;

        function automatic int blen(input ent_t h);
            return 1 + EC + ((!h.rs && h.db == 8'h01) ? CC : WC);
        endfunction

        task automatic push_ref(input logic [15:0] d);
            logic [3:0] n;
            q.push_back({1'b0, 1'b0, 8'hCE});
            for (int i = 0; i < ND; i++) begin
                n = d[4*(ND-1-i) +: 4];
                q.push_back({(i == ND-1), 1'b1, (n < 4'd10) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10});
            end
        endtask

        // advance the model on each active edge using the sampled inputs
        initial begin
            ent_t h;
            forever begin
                @(posedge clk);
                if (!rst_n_s[g]) begin
                    live = 1; jr = 1; pwr = PW; off = 0; ldb = 8'h00; lrs = 1'b0;
                    q.delete();
                    q.push_back({2'b00, 8'h38});
                    q.push_back({2'b00, 8'h0C});
                    q.push_back({2'b00, 8'h06});
                    q.push_back({2'b00, 8'h01});
                end else begin
                    jr = 0;
                    if (live) begin
                        if (pwr > 0) pwr--;
                        else if (q.size() > 0) begin
                            off++;
                            if (off == blen(q[0])) begin
                                h = q.pop_front();
                                off = 0; ldb = h.db; lrs = h.rs;
                                if (h.fin && AUTO) push_ref(dig_s[g]);
                            end
                        end else if (start_s[g]) push_ref(dig_s[g]);
                    end
                end
            end
        end

        // compare every cycle once the DUT has seen a reset
        initial begin
            ent_t h;
            logic xe, xrs, xr, xd;
            logic [7:0] xdb;
            forever begin
                @(negedge clk);
                if (live) begin
                    if (pwr > 0 || q.size() == 0) begin
                        xe = 0; xdb = ldb; xrs = lrs; xd = 0; xr = (pwr == 0);
                    end else begin
                        h = q[0];
                        xe = (off >= 1 && off <= EC); xdb = h.db; xrs = h.rs; xr = 0;
                        xd = h.fin && (off == blen(h) - 1);
                    end
                    chk($sformatf("d%0d_outs(e,rs,db,rdy,done,rw)", g),
                        {e_w[g], rs_w[g], db_w[g], rdy_w[g], done_w[g], rw_w[g]},
                        {xe, xrs, xdb, xr, xd, 1'b0});
                    if (pe && !jr)
                        chk($sformatf("d%0d_db_stable_while_e", g), {rs_w[g], db_w[g]}, pv);
                    pe = e_w[g];
                    pv = {rs_w[g], db_w[g]};
                end
            end
        end
    end

    // ---------------- event capture for literal checks ----------------
    int rcyc0 = 0, first_rise = -1, ready_cyc = -1, acc_cyc = -1, done_cyc = -1, done_cnt = 0;
    int rdy1_cnt = 0, ce1_cnt = 0;
    logic [8:0] log0[$], log1[$];
    bit pe0 = 0, pr0 = 0, pe1 = 0, cnt1_on = 0;

    initial forever begin
        @(posedge clk);
        rcyc0 = rst_n_s[0] ? rcyc0 + 1 : 0;
    end

    initial forever begin
        @(negedge clk);
        if (e_w[0] === 1'b1 && !pe0) begin
            log0.push_back({rs_w[0], db_w[0]});
            if (first_rise < 0) first_rise = rcyc0;
        end
        if (rdy_w[0] === 1'b1 && !pr0 && ready_cyc < 0) ready_cyc = rcyc0;
        if (rdy_w[0] === 1'b1 && start_s[0]) acc_cyc = rcyc0;
        if (done_w[0] === 1'b1) begin done_cnt++; done_cyc = rcyc0; end
        pe0 = (e_w[0] === 1'b1);
        pr0 = (rdy_w[0] === 1'b1);
        if (e_w[1] === 1'b1 && !pe1) begin
            log1.push_back({rs_w[1], db_w[1]});
            if ({rs_w[1], db_w[1]} == 9'h0CE) ce1_cnt++;
        end
        if (cnt1_on && rdy_w[1] === 1'b1) rdy1_cnt++;
        pe1 = (e_w[1] === 1'b1);
    end

    function automatic logic [8:0] get_log(input int d, input int i);
        if (d == 0) return (i < log0.size()) ? log0[i] : 9'h1FF;
        return (i < log1.size()) ? log1[i] : 9'h1FF;
    endfunction

    task automatic chk_ref(input string nm, input int d, input int base, input logic [31:0] asc);
        chk({nm, "_addr"}, get_log(d, base), 9'h0CE);
        for (int i = 0; i < ND; i++)
            chk($sformatf("%s_byte%0d", nm, i), get_log(d, base + 1 + i), {1'b1, asc[31-8*i -: 8]});
    endtask

    task automatic chk_init(input string nm);
        logic [7:0] c[4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
        chk({nm, "_count"}, log0.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_cmd%0d", nm, i), get_log(0, i), {1'b0, c[i]});
    endtask

    task automatic wait_rdy(input int lim, input string nm);
        int n = 0;
        @(negedge clk);
        while (rdy_w[0] !== 1'b1 && n < lim) begin @(negedge clk); n++; end
        if (rdy_w[0] !== 1'b1) chk({nm, "_ready_timeout"}, 0, 1);
    endtask

    task automatic pulse0(input logic [15:0] d);
        @(posedge clk); #1 dig_s[0] = d; start_s[0] = 1'b1;
        @(posedge clk); #1 start_s[0] = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        rst_n_s = 2'b00; start_s = 2'b00; dig_s = '0;
        repeat (3) @(posedge clk);
        #1 rst_n_s = 2'b11;
        @(negedge clk);
        chk("reset_outs", {e_w[0], rs_w[0], db_w[0], rdy_w[0], done_w[0], rw_w[0]}, 0);

        // 1: power-up and init
        wait_rdy(100, "init");
        chk("first_e_rise_cycle", first_rise, 11);
        chk("ready_cycle", ready_cyc, 36);
        chk_init("init");

        // 2: refresh 1234 on dut0, 5AC0 on dut1 (auto)
        log0.delete(); done_cnt = 0;
        @(posedge clk); #1 dig_s[0] = 16'h1234; dig_s[1] = 16'h5AC0; start_s = 2'b11;
        @(posedge clk); #1 start_s = 2'b00; cnt1_on = 1; dig_s[1] = 16'h9BDE;
        wait_rdy(100, "r1234");
        chk("done_pulses", done_cnt, 1);
        chk("done_latency", done_cyc - acc_cyc, 30);
        chk_ref("r1234", 0, 0, 32'h31323334);

        // 3: hex letters
        log0.delete();
        start_s[1] = 1'b1;
        pulse0(16'hA0F9);
        wait_rdy(100, "rA0F9");
        chk_ref("rA0F9", 0, 0, 32'h41304639);

        // 4: start held, digits changed mid-refresh
        log0.delete(); done_cnt = 0;
        @(posedge clk); #1 dig_s[0] = 16'h0F0F; start_s[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1 dig_s[0] = 16'hFFFF;
        n = 0;
        @(negedge clk);
        while (done_w[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (done_w[0] !== 1'b1) chk("hold_done_timeout", 0, 1);
        @(posedge clk);
        @(posedge clk); #1 start_s[0] = 1'b0;
        wait_rdy(100, "hold");
        chk("hold_bytes", log0.size(), 10);
        chk_ref("hold1", 0, 0, 32'h30463046);
        chk_ref("hold2", 0, 5, 32'h46464646);
        chk("hold_done_pulses", done_cnt, 2);

        // 5: reset during a PULSE phase
        pulse0(16'h1234);
        n = 0;
        @(negedge clk);
        while (e_w[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (e_w[0] !== 1'b1) chk("pulse_timeout", 0, 1);
        @(posedge clk); #1 rst_n_s[0] = 1'b0; first_rise = -1; ready_cyc = -1;
        @(posedge clk); #1 rst_n_s[0] = 1'b1; log0.delete();
        @(negedge clk);
        chk("midrst_outs", {e_w[0], rs_w[0], db_w[0], rdy_w[0], done_w[0]}, 0);
        wait_rdy(100, "reinit");
        chk("re_first_e_rise_cycle", first_rise, 11);
        chk("re_ready_cycle", ready_cyc, 36);
        chk_init("reinit");

        // 6: auto refresh keeps running without start
        n = 0;
        while (ce1_cnt < 3 && n < 300) begin @(negedge clk); n++; end
        chk("auto_ce_repeats", (ce1_cnt >= 3), 1);
        chk("auto_ready_never", rdy1_cnt, 0);
        chk_ref("auto1", 1, 4, 32'h35414330);
        chk_ref("auto2", 1, 9, 32'h39424445);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
